multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 34 +++
 rtl/multicycle_control.sv | 152 +++++++++++++++
 tb/tb_multicycle_control.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction opcode, memory handshake and datapath strobes.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, instr_done, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_op, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: registered Moore strobes per state; memory-handshake
// strobes (ir_write, fetch pc_write, sw retire) qualify on mem_ready and stall with it.
module multicycle_control #(
    parameter int ILLEGAL_HALT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        REXEC, RWB, IEXEC, IWB, BRANCH, JUMP, HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       done;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     state;
    state_t     nxt;
    logic [5:0] op_q;
    logic [5:0] op_src;
    ctl_t       ctl_q;
    logic       illegal_q;
    logic       fetch_hit;
    logic       store_hit;

    function automatic logic [3:0] imm_alu_op(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b0010;
            3'd1:    return 4'b0100;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b1000;
            3'd6:    return 4'b1001;
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_J) || (op[5:3] == 3'b001);
    endfunction

    function automatic ctl_t decode(input state_t s, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 4'b0010; end
            DECODE: begin c.alu_src_b = 2'b11; c.alu_op = 4'b0010; end
            MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0010; end
            MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
            MEMWR:  begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
            REXEC:  begin c.alu_src_a = 1'b1; c.alu_op = 4'b0000; end
            RWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
            IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = imm_alu_op(op[2:0]); end
            IWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
            BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 4'b0001; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.done = 1'b1;
            end
            JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.done = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign op_src = (state == DECODE) ? bus.opcode : op_q;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = FETCH;
            FETCH:  if (bus.mem_ready) nxt = DECODE;
            DECODE: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) nxt = MEMADR;
                else if (bus.opcode == OP_RTYPE)                nxt = REXEC;
                else if (bus.opcode == OP_BEQ)                  nxt = BRANCH;
                else if (bus.opcode == OP_J)                    nxt = JUMP;
                else if (bus.opcode[5:3] == 3'b001)             nxt = IEXEC;
                else if (ILLEGAL_HALT != 0)                     nxt = HALT;
                else                                            nxt = FETCH;
            end
            MEMADR: nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (bus.mem_ready) nxt = MEMWB;
            MEMWR:  if (bus.mem_ready) nxt = FETCH;
            REXEC:  nxt = RWB;
            IEXEC:  nxt = IWB;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            ctl_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= nxt;
            ctl_q <= decode(nxt, op_src);
            if (state == DECODE) begin
                op_q <= bus.opcode;
                if (!is_legal(bus.opcode)) illegal_q <= 1'b1;
            end
        end
    end

    assign fetch_hit = (state == FETCH) && bus.mem_ready;
    assign store_hit = (state == MEMWR) && bus.mem_ready;

    // Outputs are forced low while reset is asserted so nothing fires in the reset cycle itself.
    assign bus.pc_write      = rst_n & (ctl_q.pc_write | fetch_hit);
    assign bus.ir_write      = rst_n & fetch_hit;
    assign bus.instr_done    = rst_n & (ctl_q.done | store_hit);
    assign bus.pc_write_cond = rst_n & ctl_q.pc_write_cond;
    assign bus.i_or_d        = rst_n & ctl_q.i_or_d;
    assign bus.mem_read      = rst_n & ctl_q.mem_read;
    assign bus.mem_write     = rst_n & ctl_q.mem_write;
    assign bus.reg_dst       = rst_n & ctl_q.reg_dst;
    assign bus.mem_to_reg    = rst_n & ctl_q.mem_to_reg;
    assign bus.reg_write     = rst_n & ctl_q.reg_write;
    assign bus.alu_src_a     = rst_n & ctl_q.alu_src_a;
    assign bus.alu_src_b     = {2{rst_n}} & ctl_q.alu_src_b;
    assign bus.pc_source     = {2{rst_n}} & ctl_q.pc_source;
    assign bus.alu_op        = {4{rst_n}} & ctl_q.alu_op;
    assign bus.illegal       = rst_n & illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-level scoreboard for multicycle_control: an instruction-level plan yields per-cycle stimulus and expected strobes.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
    } drv_t;

    typedef struct {
        ctl_t  c;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;

    multicycle_control_if bus0 ();
    multicycle_control_if bus1 ();

    multicycle_control #(.ILLEGAL_HALT(0)) u_dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
    multicycle_control #(.ILLEGAL_HALT(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

    always #5 clk = ~clk;

    drv_t drv_q[$];
    exp_t exp_q[$];
    logic sticky = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic ctl_t sample(input int which);
        ctl_t a;
        if (which == 0) begin
            a = '{bus0.pc_write, bus0.pc_write_cond, bus0.i_or_d, bus0.mem_read, bus0.mem_write,
                  bus0.ir_write, bus0.reg_dst, bus0.mem_to_reg, bus0.reg_write, bus0.alu_src_a,
                  bus0.alu_src_b, bus0.pc_source, bus0.alu_op, bus0.instr_done, bus0.illegal};
        end else begin
            a = '{bus1.pc_write, bus1.pc_write_cond, bus1.i_or_d, bus1.mem_read, bus1.mem_write,
                  bus1.ir_write, bus1.reg_dst, bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a,
                  bus1.alu_src_b, bus1.pc_source, bus1.alu_op, bus1.instr_done, bus1.illegal};
        end
        return a;
    endfunction

    task automatic check(input string tag, input ctl_t act, input ctl_t want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b want %b", tag, $time, act, want);
        end
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op,
                        input ctl_t e, input string tag);
        exp_t x;
        drv_q.push_back('{rst, rdy, op});
        x.c = rst ? e : '0;
        x.c.illegal = rst & sticky;
        x.tag = tag;
        exp_q.push_back(x);
        if (!rst) sticky = 1'b0;
    endtask

    function automatic logic [3:0] imm_class(input logic [5:0] op);
        case (op)
            6'h08: return 4'b0010;
            6'h09: return 4'b0100;
            6'h0A: return 4'b0101;
            6'h0B: return 4'b0110;
            6'h0C: return 4'b0111;
            6'h0D: return 4'b1000;
            6'h0E: return 4'b1001;
            default: return 4'b0011;
        endcase
    endfunction

    task automatic reset_seq(input int n);
        repeat (n) push(1'b0, 1'($urandom_range(0, 1)), rnd_op(), '0, "reset");
        push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), '0, "idle");
    endtask

    task automatic fetch_phase(input int fs);
        ctl_t e;
        e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = 4'b0010;
        repeat (fs) push(1'b1, 1'b0, rnd_op(), e, "fetch_wait");
        e.ir_write = 1; e.pc_write = 1;
        push(1'b1, 1'b1, rnd_op(), e, "fetch");
    endtask

    // One instruction: fs fetch stalls, ms data-memory stalls; opcode is random outside decode.
    task automatic plan_instr(input logic [5:0] op, input int fs, input int ms);
        ctl_t e;
        fetch_phase(fs);
        e = '0; e.alu_src_b = 2'd3; e.alu_op = 4'b0010;
        push(1'b1, 1'($urandom_range(0, 1)), op, e, "decode");
        if (op == 6'h23 || op == 6'h2B) begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 4'b0010;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "memadr");
            e = '0; e.i_or_d = 1;
            if (op == 6'h23) begin
                e.mem_read = 1;
                repeat (ms) push(1'b1, 1'b0, rnd_op(), e, "memrd_wait");
                push(1'b1, 1'b1, rnd_op(), e, "memrd");
                e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
                push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "memwb");
            end else begin
                e.mem_write = 1;
                repeat (ms) push(1'b1, 1'b0, rnd_op(), e, "memwr_wait");
                e.instr_done = 1;
                push(1'b1, 1'b1, rnd_op(), e, "memwr");
            end
        end else if (op == 6'h00) begin
            e = '0; e.alu_src_a = 1; e.alu_op = 4'b0000;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "rexec");
            e = '0; e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "rwb");
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = imm_class(op);
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "iexec");
            e = '0; e.reg_write = 1; e.instr_done = 1;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "iwb");
        end else if (op == 6'h04) begin
            e = '0; e.alu_src_a = 1; e.alu_op = 4'b0001; e.pc_write_cond = 1;
            e.pc_source = 2'd1; e.instr_done = 1;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "branch");
        end else if (op == 6'h02) begin
            e = '0; e.pc_write = 1; e.pc_source = 2'd2; e.instr_done = 1;
            push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), e, "jump");
        end else begin
            sticky = 1'b1;
        end
    endtask

    task automatic run_driver();
        drv_t d;
        while (drv_q.size() > 0) begin
            @(posedge clk);
            #1;
            d = drv_q.pop_front();
            rst0_n         = d.rst;
            bus0.mem_ready = d.rdy;
            bus0.opcode    = d.op;
        end
    endtask

    task automatic run_monitor();
        exp_t x;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            x = exp_q.pop_front();
            check(x.tag, sample(0), x.c);
        end
    endtask

    task automatic run_halt_dut();
        ctl_t e;
        bus1.mem_ready = 1'b1;
        bus1.opcode    = 6'h3F;
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1;
        @(negedge clk); check("halt_idle", sample(1), '0);
        @(negedge clk);
        e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = 4'b0010; e.ir_write = 1; e.pc_write = 1;
        check("halt_fetch", sample(1), e);
        @(negedge clk);
        e = '0; e.alu_src_b = 2'd3; e.alu_op = 4'b0010;
        check("halt_decode", sample(1), e);
        e = '0; e.illegal = 1;
        repeat (10) begin
            @(negedge clk); check("halt_hold", sample(1), e);
        end
        @(posedge clk); #1 rst1_n = 1'b0;
        @(negedge clk); check("halt_rst", sample(1), '0);
        @(posedge clk); #1 rst1_n = 1'b1;
        @(negedge clk); check("halt_rst_idle", sample(1), '0);
        @(negedge clk);
        e = '0; e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = 4'b0010; e.ir_write = 1; e.pc_write = 1;
        check("halt_refetch", sample(1), e);
    endtask

    initial begin
        logic [5:0] ops [16];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h09, 6'h0A,
                6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h01, 6'h10};
        bus0.mem_ready = 1'b0;
        bus0.opcode    = '0;
        bus1.mem_ready = 1'b0;
        bus1.opcode    = '0;

        reset_seq(2);
        plan_instr(6'h23, 0, 0);
        plan_instr(6'h00, 0, 0);
        plan_instr(6'h0E, 0, 0);
        plan_instr(6'h2B, 0, 3);
        plan_instr(6'h04, 0, 0);
        plan_instr(6'h02, 0, 0);
        plan_instr(6'h3F, 0, 0);
        plan_instr(6'h23, 2, 2);
        fetch_phase(2);
        void'(drv_q.pop_back());
        void'(exp_q.pop_back());
        push(1'b0, 1'b1, rnd_op(), '0, "rst_fetch_stall");
        push(1'b1, 1'($urandom_range(0, 1)), rnd_op(), '0, "idle");
        for (int i = 0; i < 40; i++)
            plan_instr(ops[$urandom_range(0, 15)], $urandom_range(0, 2), $urandom_range(0, 3));

        fork
            run_driver();
            run_monitor();
            run_halt_dut();
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
